// File: rtl/ns73m_writer.sv
// ns73m_writer: NS73M CK/DA/LA register programming bus master.
// One 4-bit address plus 8-bit data frame per request, LSB first, then latch.
module ns73m_writer #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk_32,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       MOD_CK,
    output logic       MOD_DA,
    output logic       MOD_LA
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        TAIL,
        LATCH
    } state_t;

    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [11:0] sr;
    logic        div_end;

    assign div_end = (div_cnt == DIV_TC);

    // Frame sequencer: divider, bit counter, shift register and bus pins.
    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            sr      <= 12'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            MOD_CK  <= 1'b0;
            MOD_DA  <= 1'b0;
            MOD_LA  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE || div_end) begin
                div_cnt <= 8'd0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        sr      <= {wr_data, wr_addr};
                        bit_cnt <= 4'd0;
                        busy    <= 1'b1;
                        MOD_CK  <= 1'b0;
                        MOD_DA  <= wr_addr[0];
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        MOD_CK <= 1'b1;
                        state  <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (div_end) begin
                        MOD_CK  <= 1'b0;
                        sr      <= {sr[0], sr[11:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd11) begin
                            // DA keeps the last bit through tail and latch
                            state <= TAIL;
                        end else begin
                            MOD_DA <= sr[1];
                            state  <= SHIFT_LO;
                        end
                    end
                end
                TAIL: begin
                    if (div_end) begin
                        MOD_LA <= 1'b1;
                        state  <= LATCH;
                    end
                end
                LATCH: begin
                    if (div_end) begin
                        MOD_LA <= 1'b0;
                        MOD_DA <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ns73m_writer.sv
// tb_ns73m_writer: randomized checks of ns73m_writer at CLK_DIV 16 and 2
// against a cycle-offset waveform model of the frame.
`timescale 1ns/1ps
module tb_ns73m_writer;

    logic       clk_32 = 1'b0;
    logic       rst_n   [2];
    logic       wr_req  [2];
    logic [3:0] wr_addr [2];
    logic [7:0] wr_data [2];
    logic       busy    [2];
    logic       done    [2];
    logic       ck      [2];
    logic       da      [2];
    logic       la      [2];

    int errs   = 0;
    int checks = 0;

    always #5 clk_32 = ~clk_32;

    ns73m_writer #(.CLK_DIV(16)) u_d16 (
        .clk_32 (clk_32),
        .rst_n  (rst_n[0]),
        .wr_req (wr_req[0]),
        .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]),
        .busy   (busy[0]),
        .done   (done[0]),
        .MOD_CK (ck[0]),
        .MOD_DA (da[0]),
        .MOD_LA (la[0])
    );

    ns73m_writer #(.CLK_DIV(2)) u_d2 (
        .clk_32 (clk_32),
        .rst_n  (rst_n[1]),
        .wr_req (wr_req[1]),
        .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]),
        .busy   (busy[1]),
        .done   (done[1]),
        .MOD_CK (ck[1]),
        .MOD_DA (da[1]),
        .MOD_LA (la[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int sel);
        return (sel != 0) ? 2 : 16;
    endfunction

    // {busy, done, ck, da, la}
    function automatic logic [4:0] outs(input int sel);
        return {busy[sel], done[sel], ck[sel], da[sel], la[sel]};
    endfunction

    // Expected pins n cycles after the accept edge, from the frame timing.
    function automatic logic [4:0] model(input int n, input int d,
                                         input logic [11:0] f);
        int k;
        if (n < 24 * d) begin
            k = n / (2 * d);
            return {1'b1, 1'b0, ((n % (2 * d)) >= d), f[k], 1'b0};
        end
        if (n < 25 * d) return {3'b100, f[11], 1'b0};
        if (n < 26 * d) return {3'b100, f[11], 1'b1};
        return 5'b01000;
    endfunction

    // mode 0 plain, 1 busy-time requests, 2 inputs change after accept,
    // 3 request held high with next frame's inputs applied at cycle 1.
    task automatic do_frame(input int sel, input logic [3:0] a,
                            input logic [7:0] dd, input int mode,
                            input logic [3:0] na, input logic [7:0] nd);
        int          d;
        logic [11:0] f;
        logic [11:0] dec;
        logic [4:0]  o;
        int          rises, la_cyc, la_pl, dn;
        logic        pck, pla;
        d = div_of(sel);
        f = {dd, a};
        dec = 12'd0;
        rises = 0;
        la_cyc = 0;
        la_pl = 0;
        dn = 0;
        pck = 1'b0;
        pla = 1'b0;
        wr_req[sel]  = 1'b1;
        wr_addr[sel] = a;
        wr_data[sel] = dd;
        @(posedge clk_32);
        @(negedge clk_32);
        for (int n = 0; n <= 26 * d; n++) begin
            o = outs(sel);
            chk($sformatf("d%0d_n%0d", d, n), 32'(o), 32'(model(n, d, f)));
            if (o[2] && !pck) begin
                if (rises < 12) dec[rises] = o[1];
                rises++;
            end
            if (o[0]) la_cyc++;
            if (o[0] && !pla) la_pl++;
            if (o[3]) dn++;
            pck = o[2];
            pla = o[0];
            if (mode == 3) begin
                if (n == 0) begin
                    wr_addr[sel] = na;
                    wr_data[sel] = nd;
                end
            end else begin
                wr_req[sel] = 1'b0;
                if (mode == 1 && (n == 5 || n == 200 || n == 26 * d - 1)) begin
                    wr_req[sel]  = 1'b1;
                    wr_addr[sel] = ~a;
                    wr_data[sel] = ~dd;
                end
                if (mode == 2 && n == 0) begin
                    wr_addr[sel] = 4'($urandom);
                    wr_data[sel] = 8'($urandom);
                end
            end
            if (n < 26 * d) begin
                @(posedge clk_32);
                @(negedge clk_32);
            end
        end
        chk("decoded", 32'(dec), 32'(f));
        chk("ck_rises", rises, 12);
        chk("la_cycles", la_cyc, d);
        chk("la_pulses", la_pl, 1);
        chk("done_cnt", dn, 1);
    endtask

    task automatic idle_chk(input int sel, input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk_32);
            @(negedge clk_32);
            chk($sformatf("idle_d%0d", div_of(sel)), 32'(outs(sel)), 32'd0);
        end
    endtask

    task automatic rst_mid(input int sel);
        int          d;
        logic [11:0] f;
        d = div_of(sel);
        f = 12'($urandom);
        wr_req[sel]  = 1'b1;
        wr_addr[sel] = f[3:0];
        wr_data[sel] = f[11:4];
        @(posedge clk_32);
        @(negedge clk_32);
        for (int n = 0; n <= 200; n++) begin
            chk($sformatf("pre_rst_n%0d", n), 32'(outs(sel)),
                32'(model(n, d, f)));
            wr_req[sel] = 1'b0;
            if (n < 200) begin
                @(posedge clk_32);
                @(negedge clk_32);
            end
        end
        rst_n[sel] = 1'b0;
        #1;
        chk("rst_async", 32'(outs(sel)), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_32);
            @(negedge clk_32);
            chk("rst_hold", 32'(outs(sel)), 32'd0);
        end
        rst_n[sel] = 1'b1;
        idle_chk(sel, 30 * d);
        do_frame(sel, 4'h3, 8'h5C, 0, 4'h0, 8'h00);
        idle_chk(sel, 2);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s]   = 1'b0;
            wr_req[s]  = 1'b1;
            wr_addr[s] = 4'h9;
            wr_data[s] = 8'h3C;
        end
        #1;
        chk("reset_d16", 32'(outs(0)), 32'd0);
        chk("reset_d2", 32'(outs(1)), 32'd0);
        @(posedge clk_32);
        @(negedge clk_32);
        chk("req_in_reset_d16", 32'(outs(0)), 32'd0);
        chk("req_in_reset_d2", 32'(outs(1)), 32'd0);
        for (int s = 0; s < 2; s++) begin
            wr_req[s] = 1'b0;
            rst_n[s]  = 1'b1;
        end
        idle_chk(0, 2);

        do_frame(0, 4'h6, 8'hA5, 0, 4'h0, 8'h00);
        idle_chk(0, 3);

        do_frame(0, 4'h0, 8'hFF, 3, 4'hF, 8'h00);
        do_frame(0, 4'hF, 8'h00, 0, 4'h0, 8'h00);
        idle_chk(0, 3);

        do_frame(0, 4'($urandom), 8'($urandom), 1, 4'h0, 8'h00);
        idle_chk(0, 5);

        do_frame(0, 4'($urandom), 8'($urandom), 2, 4'h0, 8'h00);
        idle_chk(0, 2);

        rst_mid(0);

        for (int i = 0; i < 100; i++) begin
            do_frame(1, 4'($urandom), 8'($urandom), 0, 4'h0, 8'h00);
            idle_chk(1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
